// File: rtl/pingpong_scope_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pingpong_scope_capture_pkg
//  Description : Shared encodings for the ping-pong scope capture buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pingpong_scope_capture_pkg;

    typedef logic [1:0] cap_state_t;
    typedef logic [1:0] trig_mode_t;

    localparam cap_state_t c_CAP_ARM  = 2'd0;
    localparam cap_state_t c_CAP_FILL = 2'd1;
    localparam cap_state_t c_CAP_FULL = 2'd2;

    localparam trig_mode_t c_TRIG_MANUAL = 2'd0;
    localparam trig_mode_t c_TRIG_RISE   = 2'd1;
    localparam trig_mode_t c_TRIG_FALL   = 2'd2;
    localparam trig_mode_t c_TRIG_AUTO   = 2'd3;

    localparam int c_SWAP_LINE_DEFAULT = 480;

endpackage
`default_nettype wire

// File: rtl/pingpong_scope_capture_dpram.sv
`default_nettype none
// ============================================================================
//  Module      : pp_dpram
//  Description : Simple dual-port RAM, one write port, one registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_dpram
    import pingpong_scope_capture_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem_q [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
        r_rdata_q <= r_mem_q[i_raddr];
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/pingpong_scope_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pingpong_scope_capture
//  Description : Triggered ADC capture into one RAM bank while the other bank
//                feeds the VGA trace; banks swap on a fixed scan line.
//  Revision    : 1.0 - initial release
// ============================================================================
module pingpong_scope_capture
    import pingpong_scope_capture_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DIV_W     = 16,
    parameter int X0        = 100,
    parameter int Y0        = 200,
    parameter int WIN_W     = 200,
    parameter int WIN_H     = 256,
    parameter int SWAP_LINE = c_SWAP_LINE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ad_data,
    input  logic [DIV_W-1:0]  div_val,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              sample_sig,
    input  logic [9:0]        value_x,
    input  logic [9:0]        value_y,
    output logic [DATA_W-1:0] ad_data_value,
    output logic              bank_sel,
    output logic              frame_done,
    output logic [1:0]        cap_state
);

    localparam logic [ADDR_W-1:0] c_WADDR_LAST = '1;

    cap_state_t        r_state_q,      w_state_d;
    logic              r_bank_q,       w_bank_d;
    logic [ADDR_W-1:0] r_waddr_q,      w_waddr_d;
    logic [DIV_W-1:0]  r_cnt_q,        w_cnt_d;
    logic [DATA_W-1:0] r_prev_q,       w_prev_d;
    logic              r_prev_valid_q, w_prev_valid_d;
    logic [1:0]        r_sync_q,       w_sync_d;
    logic [ADDR_W-1:0] r_raddr_q,      w_raddr_d;
    logic [DATA_W-1:0] r_dout_q,       w_dout_d;
    logic              r_done_q,       w_done_d;

    logic              w_tick;
    logic              w_sig_rise;
    logic              w_start;
    logic              w_swap_line;
    logic              w_in_win;
    logic              w_fill_we;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_q [2];

    // Divider: the >= compare lets a lowered div_val take effect at once.
    assign w_tick     = (r_cnt_q >= div_val);
    assign w_cnt_d    = w_tick ? '0 : r_cnt_q + DIV_W'(1);
    assign w_sync_d   = {r_sync_q[0], sample_sig};
    assign w_sig_rise = r_sync_q[0] & ~r_sync_q[1];
    assign w_swap_line = (value_y == 10'(SWAP_LINE)) && (value_x == 10'd0);

    always_comb begin
        w_start = 1'b0;
        case (trig_mode)
            c_TRIG_MANUAL: w_start = w_sig_rise;
            c_TRIG_RISE:   w_start = w_tick && r_prev_valid_q &&
                                     (r_prev_q < trig_level) && (trig_level <= ad_data);
            c_TRIG_FALL:   w_start = w_tick && r_prev_valid_q &&
                                     (r_prev_q > trig_level) && (trig_level >= ad_data);
            default:       w_start = w_tick;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= c_CAP_ARM;
            r_bank_q       <= 1'b0;
            r_waddr_q      <= '0;
            r_cnt_q        <= '0;
            r_prev_q       <= '0;
            r_prev_valid_q <= 1'b0;
            r_sync_q       <= '0;
            r_raddr_q      <= '0;
            r_dout_q       <= '0;
            r_done_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_bank_q       <= w_bank_d;
            r_waddr_q      <= w_waddr_d;
            r_cnt_q        <= w_cnt_d;
            r_prev_q       <= w_prev_d;
            r_prev_valid_q <= w_prev_valid_d;
            r_sync_q       <= w_sync_d;
            r_raddr_q      <= w_raddr_d;
            r_dout_q       <= w_dout_d;
            r_done_q       <= w_done_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_CAP_ARM:  if (w_start) w_state_d = c_CAP_FILL;
            c_CAP_FILL: if (w_tick && (r_waddr_q == c_WADDR_LAST)) w_state_d = c_CAP_FULL;
            c_CAP_FULL: if (w_swap_line) w_state_d = c_CAP_ARM;
            default:    w_state_d = c_CAP_ARM;
        endcase
    end

    always_comb begin
        w_fill_we      = 1'b0;
        w_wr_addr      = r_waddr_q;
        w_waddr_d      = r_waddr_q;
        w_bank_d       = r_bank_q;
        w_done_d       = 1'b0;
        w_prev_d       = w_tick ? ad_data : r_prev_q;
        w_prev_valid_d = r_prev_valid_q | w_tick;
        case (r_state_q)
            c_CAP_ARM: begin
                if (w_start) begin
                    if (trig_mode == c_TRIG_MANUAL) begin
                        w_waddr_d = '0;
                    end else begin
                        // Triggering sample becomes address 0 of the frame.
                        w_fill_we = 1'b1;
                        w_wr_addr = '0;
                        w_waddr_d = ADDR_W'(1);
                    end
                end
            end
            c_CAP_FILL: begin
                if (w_tick) begin
                    w_fill_we = 1'b1;
                    if (r_waddr_q != c_WADDR_LAST) w_waddr_d = r_waddr_q + ADDR_W'(1);
                end
            end
            c_CAP_FULL: begin
                if (w_swap_line) begin
                    w_bank_d       = ~r_bank_q;
                    w_done_d       = 1'b1;
                    w_prev_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // RAM read is addressed with next raddr so value_x reaches the output in 2 clk.
    assign w_in_win = (int'(value_x) >= X0) && (int'(value_x) < X0 + WIN_W) &&
                      (int'(value_y) >= Y0) && (int'(value_y) < Y0 + WIN_H);
    assign w_raddr_d = rst      ? '0 :
                       w_in_win ? ADDR_W'(value_x - 10'(X0)) : r_raddr_q;
    assign w_dout_d  = r_bank_q ? w_q[0] : w_q[1];

    for (genvar k = 0; k < 2; k++) begin : g_bank
        logic w_we;
        assign w_we = w_fill_we & ~rst & (r_bank_q == (k != 0));
        pp_dpram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_we),
            .i_waddr (w_wr_addr),
            .i_wdata (ad_data),
            .i_raddr (w_raddr_d),
            .o_rdata (w_q[k])
        );
    end

    assign ad_data_value = r_dout_q;
    assign bank_sel      = r_bank_q;
    assign frame_done    = r_done_q;
    assign cap_state     = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_scope_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pingpong_scope_capture
//  Description : Scoreboard bench; frames are predicted from the logged tick
//                samples and read back through the display path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_scope_capture;

    localparam int DATA_W = 8, ADDR_W = 8, DIV_W = 16;
    localparam int X0 = 100, Y0 = 200, WIN_W = 200, WIN_H = 256, SWAP_LINE = 480;
    localparam int DEPTH = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] ad_data = '0;
    logic [DIV_W-1:0]  div_val = '0;
    logic [1:0]        trig_mode = 2'd2;
    logic [DATA_W-1:0] trig_level = 8'd128;
    logic              sample_sig = 1'b0;
    logic [9:0]        value_x = '0;
    logic [9:0]        value_y = '0;
    logic [DATA_W-1:0] ad_data_value;
    logic              bank_sel;
    logic              frame_done;
    logic [1:0]        cap_state;

    pingpong_scope_capture #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W), .X0(X0), .Y0(Y0),
        .WIN_W(WIN_W), .WIN_H(WIN_H), .SWAP_LINE(SWAP_LINE)
    ) dut (
        .clk(clk), .rst(rst), .ad_data(ad_data), .div_val(div_val),
        .trig_mode(trig_mode), .trig_level(trig_level), .sample_sig(sample_sig),
        .value_x(value_x), .value_y(value_y), .ad_data_value(ad_data_value),
        .bank_sel(bank_sel), .frame_done(frame_done), .cap_state(cap_state)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [7:0] exp; } rd_t;

    int         n_pass = 0, n_total = 0;
    int         cyc = 0;
    int         done_count = 0;
    int         d_cur = 0, n_edge = 0;
    rd_t        rd_q[$];
    logic       sb_swap[$];
    logic [7:0] tlog_v[$];
    int         tlog_e[$];
    logic [7:0] mb [2][DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Monitor: swap events and display reads are popped as the DUT presents them.
    always @(negedge clk) begin
        rd_t  e;
        logic b;
        if (frame_done === 1'b1) begin
            done_count++;
            if (sb_swap.size() == 0) check("frame_done_unexpected", 1, 0);
            else begin
                b = sb_swap.pop_front();
                check("bank_sel_at_swap", int'(bank_sel), int'(b));
            end
        end
        while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            e = rd_q.pop_front();
            if (e.due == cyc) check("ad_data_value", int'(ad_data_value), int'(e.exp));
            else check("read_missed", e.due, cyc);
        end
    end

    task automatic step(input logic [7:0] ad);
        ad_data = ad;
        @(posedge clk);
        n_edge++;
        if (n_edge % (d_cur + 1) == 0) begin
            tlog_v.push_back(ad);
            tlog_e.push_back(n_edge);
        end
        #1;
    endtask

    task automatic do_reset(input int d);
        d_cur = d;
        div_val = DIV_W'(d);
        sample_sig = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_edge = 0;
        tlog_v.delete();
        tlog_e.delete();
        check("rst_cap_state", int'(cap_state), 0);
        check("rst_bank_sel", int'(bank_sel), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_ad_data_value", int'(ad_data_value), 0);
    endtask

    // First written tick of a frame, searched from the ticks logged since arming.
    function automatic int find_start(input int mode, input logic [7:0] lvl,
                                      input int start_edge, input int base);
        for (int j = base; j < tlog_v.size(); j++) begin
            case (mode)
                0: if (start_edge >= 0 && tlog_e[j] > start_edge) return j;
                1: if (j > 0 && tlog_v[j-1] < lvl && lvl <= tlog_v[j]) return j;
                2: if (j > 0 && tlog_v[j-1] > lvl && lvl >= tlog_v[j]) return j;
                default: return j;
            endcase
        end
        return -1;
    endfunction

    task automatic run_capture(input int mode, input logic [7:0] lvl, input int kind, input int bank);
        int         base, idx, start_edge, pulse2, ph, p, t;
        logic [7:0] ad;
        bit         done;
        base = tlog_v.size();
        idx = -1; start_edge = -1; pulse2 = 0; done = 0;
        ph = $urandom_range(0, 63);
        trig_mode = 2'(mode);
        trig_level = lvl;
        value_x = '0;
        value_y = '0;
        for (int k = 0; k < 6000 && !done; k++) begin
            if (mode == 0) begin
                if (k == 3) sample_sig = 1'b1;
                if (k == 6) sample_sig = 1'b0;
                if (idx >= 0 && pulse2 == 0 && tlog_v.size() >= idx + 100) pulse2 = k;
                if (pulse2 > 0) sample_sig = (k < pulse2 + 3);
            end
            case (kind)
                0: ad = 8'($urandom_range(0, 255));
                1: ad = 8'(k);
                2: begin
                    p = (k + ph) % 64;
                    t = (p < 32) ? p : 63 - p;
                    ad = 8'(40 + t * 6);
                end
                3: ad = 8'(k + 1);
                default: ad = 8'd200;
            endcase
            step(ad);
            if (mode == 0 && k == 3) start_edge = n_edge + 1;
            idx = find_start(mode, lvl, start_edge, base);
            if (idx >= 0 && tlog_v.size() == idx + DEPTH - 1)
                check("state_fill_before_last", int'(cap_state), 1);
            if (idx >= 0 && tlog_v.size() >= idx + DEPTH) done = 1;
        end
        sample_sig = 1'b0;
        if (!done) begin
            check("capture_timeout", 0, 1);
            return;
        end
        check("state_full_after_frame", int'(cap_state), 2);
        for (int a = 0; a < DEPTH; a++) mb[bank][a] = tlog_v[idx + a];
    endtask

    task automatic do_swap(input logic exp_bs);
        trig_mode = 2'd2;
        trig_level = 8'd128;
        value_x = '0;
        value_y = 10'(SWAP_LINE);
        sb_swap.push_back(exp_bs);
        step(8'd200);
        tlog_v.delete();
        tlog_e.delete();
        value_y = '0;
        step(8'd200);
        step(8'd200);
        check("swap_seen", sb_swap.size(), 0);
        check("state_arm_after_swap", int'(cap_state), 0);
    endtask

    task automatic push_rd(input logic [7:0] exp);
        rd_t e;
        e.due = cyc + 2;
        e.exp = exp;
        rd_q.push_back(e);
    endtask

    task automatic readback(input int bank);
        value_y = 10'd300;
        for (int x = X0; x < X0 + WIN_W; x++) begin
            value_x = 10'(x);
            push_rd(mb[bank][x - X0]);
            step(8'd200);
        end
        value_y = 10'd100;
        value_x = 10'($urandom_range(X0, X0 + WIN_W - 1));
        push_rd(mb[bank][WIN_W - 1]);
        step(8'd200);
        value_y = 10'd300;
        value_x = 10'($urandom_range(0, X0 - 1));
        push_rd(mb[bank][WIN_W - 1]);
        step(8'd200);
        value_x = 10'(X0 + 50);
        push_rd(mb[bank][50]);
        step(8'd200);
        value_y = '0;
        value_x = '0;
        push_rd(mb[bank][50]);
        step(8'd200);
        for (int i = 0; i < 3; i++) step(8'd200);
        check("reads_drained", rd_q.size(), 0);
    endtask

    initial begin
        int dc;

        // Auto mode, ramp data, then a second frame into bank 1 without reset.
        do_reset(0);
        run_capture(3, 8'd128, 1, 0);
        do_swap(1'b1);
        readback(0);
        run_capture(3, 8'd128, 0, 1);
        do_swap(1'b0);
        readback(1);

        // Rising-level trigger through 128 with a slow sample rate.
        do_reset(4);
        run_capture(1, 8'd128, 2, 0);
        do_swap(1'b1);
        readback(0);

        // Falling trigger on constant data never fires, even on the swap line.
        do_reset($urandom_range(0, 2));
        dc = done_count;
        trig_mode = 2'd2;
        trig_level = 8'd128;
        for (int i = 0; i < 300; i++) step(8'd200);
        value_x = '0;
        value_y = 10'(SWAP_LINE);
        for (int i = 0; i < 40; i++) step(8'd200);
        value_y = '0;
        check("fall_const_stays_arm", int'(cap_state), 0);
        check("fall_const_no_frame_done", done_count - dc, 0);

        // Manual start with a second pulse during the fill.
        do_reset(1);
        run_capture(0, 8'd128, 0, 0);
        do_swap(1'b1);
        readback(0);

        // Display bank holds i+1; column 150 of row 300 reads 51.
        do_reset(0);
        run_capture(3, 8'd128, 3, 0);
        do_swap(1'b1);
        readback(0);
        value_x = 10'd150;
        value_y = 10'd300;
        step(8'd200);
        step(8'd200);
        check("read_x150_y300", int'(ad_data_value), 51);
        value_y = 10'd100;
        value_x = 10'd20;
        step(8'd200);
        step(8'd200);
        check("read_hold_y100", int'(ad_data_value), 51);
        value_y = '0;
        value_x = '0;

        // Reset in the middle of a fill, then a clean frame from address 0.
        do_reset(0);
        trig_mode = 2'd3;
        while (tlog_v.size() < 77) step(8'($urandom_range(0, 255)));
        for (int a = 0; a < 77; a++) mb[0][a] = tlog_v[a];
        check("mid_fill_state", int'(cap_state), 1);
        do_reset(0);
        run_capture(3, 8'd128, 0, 0);
        do_swap(1'b1);
        readback(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pingpong_scope_capture.md
Name: pingpong_scope_capture

Overview:
- Parametrised ping-pong capture buffer for the VGA scope path.
- Samples ad_data at a runtime-programmable rate into one RAM bank while the other bank is read by the VGA pixel scan.
- Supports manual, level-trigger (rising/falling) and auto start modes.
- Swaps banks only on a configured scan line, so the display never tears.

Parameters:
- DATA_W, 8, ADC sample width
- ADDR_W, 8, bank address width; bank depth = 2**ADDR_W
- DIV_W, 16, width of sample-period divider
- X0, 100, first display column of the trace window
- Y0, 200, first display row of the trace window
- WIN_W, 200, trace window width in pixels (≤ 2**ADDR_W)
- WIN_H, 256, trace window height in pixels
- SWAP_LINE, 480, value_y at which a pending bank swap is committed

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ad_data  in  DATA_W  ADC sample
- div_val  in  DIV_W  sample period minus 1 (0 = every clk)
- trig_mode  in  2  0 manual, 1 rising level, 2 falling level, 3 auto
- trig_level  in  DATA_W  threshold for modes 1/2
- sample_sig  in  1  manual start request (mode 0), asynchronous level
- value_x  in  10  VGA column
- value_y  in  10  VGA row
- ad_data_value  out  DATA_W  display-bank sample for current column
- bank_sel  out  1  bank currently being written (0/1)
- frame_done  out  1  one-cycle pulse on bank swap
- cap_state  out  2  0 ARM, 1 FILL, 2 FULL

Behaviour:
- Reset (sync, rst=1 at clk edge): state ARM, bank_sel=0, write address 0, divider 0, prev_valid 0, ad_data_value 0, frame_done 0, read address 0. Reset mid-fill discards the partial frame; RAM contents are not cleared.
- sample_sig passes through a 2-flop synchroniser. A rising edge is detected on the synchronised pair.
- Divider: cnt increments each clk. When cnt ≥ div_val: tick=1 and cnt←0. The ≥ comparison makes a reduced div_val take effect within one cycle.
- On each tick: prev_sample←ad_data, prev_valid←1.
- ARM: entered with prev_valid←0. Start condition:
  - mode 0: synchronised sample_sig rising edge.
  - mode 1: tick with prev_valid and prev_sample < trig_level ≤ ad_data.
  - mode 2: tick with prev_valid and prev_sample > trig_level ≥ ad_data.
  - mode 3: first tick.
  - Modes 1–3: the triggering sample is written at address 0 in the same cycle; waddr←1; go to FILL.
  - Mode 0: waddr←0; go to FILL; the first sample is written on the next tick.
- FILL: on each tick, write ad_data to write bank at waddr, then waddr+1. The write at address 2**ADDR_W-1 moves the state to FULL; waddr does not wrap.
- FULL: no writes. Commit the swap when value_y==SWAP_LINE and value_x==0: bank_sel toggles, frame_done=1 for one cycle, state→ARM.
  - Swap waits indefinitely for the line.
  - trig_mode changes are sampled only in ARM.
- Simultaneous events:
  - A sample_sig edge in FILL/FULL is ignored.
  - A tick in the swap cycle is not written.
  - A trigger and a tick in the same cycle count as one write.
- Read side: if X0 ≤ value_x < X0+WIN_W and Y0 ≤ value_y < Y0+WIN_H, raddr←value_x−X0 (truncated to ADDR_W); otherwise raddr holds.
  - The display bank is !bank_sel. RAM read latency is 1 clk; ad_data_value is registered from display-bank q.
  - Total latency value_x→ad_data_value is 2 clk.
- Write and read never target the same bank, so there is no read/write collision.
- Arithmetic: all comparisons are unsigned. DIV_W counters saturate nowhere; cnt is bounded by div_val.

Decomposition:
- Shared package holds:
  - cap_state encoding (ARM=0, FILL=1, FULL=2)
  - trig_mode encoding (MANUAL=0, RISE=1, FALL=2, AUTO=3)
  - default SWAP_LINE
- One sub-module, pp_dpram: simple dual-port RAM (DATA_W, ADDR_W), one write port, one registered read port, inferred. Instantiated twice.
- Bank write-enable is fill_we & (bank_sel==k).

Test Plan:
- Reset then mode 3, div_val=0, ad_data ramps 0..255 → bank0 holds 0..255 (address = value); cap_state=FULL after 256 clk; at (x=0, y=480) frame_done pulses once and bank_sel=1.
- Mode 1, trig_level=128, div_val=4, ad_data sine through 128 → address 0 holds the first sample ≥128 whose preceding tick sample was <128; no writes before the crossing.
- Mode 2, trig_level=128, ad_data constant 200 → state stays ARM forever; frame_done never pulses.
- Mode 0, sample_sig pulse 3 clk wide → exactly one fill starts; a second pulse during FILL is ignored. Frame ends after 256 ticks.
- Read: display bank preloaded with data[i]=i+1 → value_x=150, value_y=300 gives ad_data_value=51 two clk later. value_y=100 keeps the previous value.
- rst asserted at waddr=77 in FILL → next cycle state ARM, bank_sel=0, ad_data_value=0. A new fill restarts at address 0.
